// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the hardwired control sequencer:
// T-state enum, opcode map, ALU operation codes and instruction classes.
package cpu_ctrl_pkg;

  localparam int OPW  = 5;
  localparam int ALUW = 5;

  typedef enum logic [3:0] {
    ST_RST,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_T7,
    ST_HALT
  } state_t;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPW-1:0] OP_BR   = 5'b10010;
  localparam logic [OPW-1:0] OP_JR   = 5'b10011;
  localparam logic [OPW-1:0] OP_IN   = 5'b10101;
  localparam logic [OPW-1:0] OP_OUT  = 5'b10110;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  localparam logic [ALUW-1:0] ALU_AND   = 5'd0;
  localparam logic [ALUW-1:0] ALU_OR    = 5'd1;
  localparam logic [ALUW-1:0] ALU_ADD   = 5'd2;
  localparam logic [ALUW-1:0] ALU_SUB   = 5'd3;
  localparam logic [ALUW-1:0] ALU_INCPC = 5'd12;

  typedef enum logic [3:0] {
    CL_LD,
    CL_LDI,
    CL_ST,
    CL_RALU,
    CL_IALU,
    CL_BR,
    CL_JR,
    CL_IN,
    CL_OUT,
    CL_NOP,
    CL_HALT
  } iclass_t;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode decoder: maps IR[31:27] to an instruction class and the ALU
// operation used by that class. Unknown opcodes decode as nop.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [OPW-1:0]  opcode,
  output iclass_t         iclass,
  output logic [ALUW-1:0] alu_op
);

  // Pure lookup; address arithmetic for ld/ldi/st/br always uses ADD.
  always_comb begin
    iclass = CL_NOP;
    alu_op = ALU_AND;
    case (opcode)
      OP_LD:   begin iclass = CL_LD;   alu_op = ALU_ADD; end
      OP_LDI:  begin iclass = CL_LDI;  alu_op = ALU_ADD; end
      OP_ST:   begin iclass = CL_ST;   alu_op = ALU_ADD; end
      OP_ADD:  begin iclass = CL_RALU; alu_op = ALU_ADD; end
      OP_SUB:  begin iclass = CL_RALU; alu_op = ALU_SUB; end
      OP_AND:  begin iclass = CL_RALU; alu_op = ALU_AND; end
      OP_OR:   begin iclass = CL_RALU; alu_op = ALU_OR;  end
      OP_ADDI: begin iclass = CL_IALU; alu_op = ALU_ADD; end
      OP_ANDI: begin iclass = CL_IALU; alu_op = ALU_AND; end
      OP_ORI:  begin iclass = CL_IALU; alu_op = ALU_OR;  end
      OP_BR:   begin iclass = CL_BR;   alu_op = ALU_ADD; end
      OP_JR:   iclass = CL_JR;
      OP_IN:   iclass = CL_IN;
      OP_OUT:  iclass = CL_OUT;
      OP_NOP:  iclass = CL_NOP;
      OP_HALT: iclass = CL_HALT;
      default: iclass = CL_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for Datapath2: fetch in T0-T2, per-class
// execute in T3-T7, then back to T0. halt parks in HALT until clr.
// Optional build macro MEM_WAIT_EN adds a MemRdy input that stretches the
// memory steps (T1, ld T6, st T7) until the memory is ready.
//
// state | meaning
// RST   | just reset, all strobes low, Run high
// T0    | PC -> MAR, Z <= PC + 1
// T1    | PC <= Z, MDR <= mem[MAR]
// T2    | IR <= MDR
// T3-T7 | execute steps of the decoded instruction class
// HALT  | stopped, Run low, left only by clr
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
  input  logic [31:0]     IR,
  input  logic            CON_FF,
`ifdef MEM_WAIT_EN
  input  logic            MemRdy,
`endif
  output logic            PCout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            InportOut,
  output logic            MARin,
  output logic            Zin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            Rin,
  output logic            CONin,
  output logic            OutportIn,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rout,
  output logic            BAout,
  output logic            Cout,
  output logic            Read,
  output logic            Write,
  output logic [ALUW-1:0] ALU_Control,
  output logic            Run
);

  state_t          state;
  iclass_t         iclass;
  logic [ALUW-1:0] alu_op;
  logic            mem_rdy;
  logic            unused_ir;

`ifdef MEM_WAIT_EN
  assign mem_rdy = MemRdy;
`else
  assign mem_rdy = 1'b1;
`endif

  // Only the opcode field steers the sequence; operand fields go to the datapath.
  assign unused_ir = ^IR[26:0];

  ctrl_decode u_decode (
    .opcode (IR[31:27]),
    .iclass (iclass),
    .alu_op (alu_op)
  );

  // State register: one T-step per clock, memory steps hold until mem_rdy.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= ST_RST;
    end else begin
      case (state)
        ST_RST: state <= ST_T0;
        ST_T0:  state <= ST_T1;
        ST_T1:  if (mem_rdy) state <= ST_T2;
        ST_T2:  state <= ST_T3;
        ST_T3: begin
          case (iclass)
            CL_HALT:                   state <= ST_HALT;
            CL_JR, CL_IN, CL_OUT, CL_NOP: state <= ST_T0;
            default:                   state <= ST_T4;
          endcase
        end
        ST_T4:  state <= ST_T5;
        ST_T5: begin
          if (iclass == CL_LD || iclass == CL_ST || iclass == CL_BR) state <= ST_T6;
          else                                                       state <= ST_T0;
        end
        ST_T6: begin
          if (iclass == CL_LD) begin
            if (mem_rdy) state <= ST_T7;
          end else if (iclass == CL_ST) begin
            state <= ST_T7;
          end else begin
            state <= ST_T0;
          end
        end
        ST_T7: begin
          if (iclass != CL_ST || mem_rdy) state <= ST_T0;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_RST;
      endcase
    end
  end

  // Strobe decode from the registered state and the IR loaded in T2; this
  // has to be combinational because IR only becomes valid in T3 itself.
  always_comb begin
    PCout       = 1'b0;
    Zlowout     = 1'b0;
    MDRout      = 1'b0;
    InportOut   = 1'b0;
    MARin       = 1'b0;
    Zin         = 1'b0;
    PCin        = 1'b0;
    MDRin       = 1'b0;
    IRin        = 1'b0;
    Yin         = 1'b0;
    Rin         = 1'b0;
    CONin       = 1'b0;
    OutportIn   = 1'b0;
    Gra         = 1'b0;
    Grb         = 1'b0;
    Grc         = 1'b0;
    Rout        = 1'b0;
    BAout       = 1'b0;
    Cout        = 1'b0;
    Read        = 1'b0;
    Write       = 1'b0;
    ALU_Control = ALU_AND;
    Run         = (state != ST_HALT);
    case (state)
      ST_T0: begin
        PCout = 1'b1; MARin = 1'b1; Zin = 1'b1; ALU_Control = ALU_INCPC;
      end
      ST_T1: begin
        Read = 1'b1; Zlowout = mem_rdy; PCin = mem_rdy; MDRin = mem_rdy;
      end
      ST_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      ST_T3: begin
        case (iclass)
          CL_LD, CL_LDI, CL_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          CL_RALU, CL_IALU:     begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CL_BR:                begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          CL_JR:                begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          CL_IN:                begin InportOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_OUT:               begin Gra = 1'b1; Rout = 1'b1; OutportIn = 1'b1; end
          default: ;
        endcase
      end
      ST_T4: begin
        case (iclass)
          CL_RALU: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_Control = alu_op; end
          CL_BR:   begin PCout = 1'b1; Yin = 1'b1; end
          default: begin Cout = 1'b1; Zin = 1'b1; ALU_Control = alu_op; end
        endcase
      end
      ST_T5: begin
        case (iclass)
          CL_LD, CL_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
          CL_BR:        begin Cout = 1'b1; Zin = 1'b1; ALU_Control = ALU_ADD; end
          default:      begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        endcase
      end
      ST_T6: begin
        case (iclass)
          CL_LD:   begin Read = 1'b1; MDRin = mem_rdy; end
          CL_ST:   begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          CL_BR:   begin Zlowout = CON_FF; PCin = CON_FF; end
          default: ;
        endcase
      end
      ST_T7: begin
        if (iclass == CL_ST) begin
          Write = 1'b1;
        end else begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer. The reference model expands each
// instruction into its list of expected per-cycle strobe sets and walks that
// list against the DUT, acting as the datapath for IR and CON_FF.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ir;
  logic        con_ff;
  logic        mem_rdy;

  logic PCout, Zlowout, MDRout, InportOut, MARin, Zin, PCin, MDRin, IRin, Yin;
  logic Rin, CONin, OutportIn, Gra, Grb, Grc, Rout, BAout, Cout, Read, Write;
  logic [4:0] ALU_Control;
  logic       Run;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .clr(clr), .IR(ir), .CON_FF(con_ff),
`ifdef MEM_WAIT_EN
    .MemRdy(mem_rdy),
`endif
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .InportOut(InportOut),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .Rin(Rin), .CONin(CONin), .OutportIn(OutportIn),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .Read(Read), .Write(Write), .ALU_Control(ALU_Control), .Run(Run)
  );

  localparam logic [20:0] S_PCOUT   = 21'b1 << 20;
  localparam logic [20:0] S_ZLOW    = 21'b1 << 19;
  localparam logic [20:0] S_MDROUT  = 21'b1 << 18;
  localparam logic [20:0] S_INPORT  = 21'b1 << 17;
  localparam logic [20:0] S_MARIN   = 21'b1 << 16;
  localparam logic [20:0] S_ZIN     = 21'b1 << 15;
  localparam logic [20:0] S_PCIN    = 21'b1 << 14;
  localparam logic [20:0] S_MDRIN   = 21'b1 << 13;
  localparam logic [20:0] S_IRIN    = 21'b1 << 12;
  localparam logic [20:0] S_YIN     = 21'b1 << 11;
  localparam logic [20:0] S_RIN     = 21'b1 << 10;
  localparam logic [20:0] S_CONIN   = 21'b1 << 9;
  localparam logic [20:0] S_OUTPORT = 21'b1 << 8;
  localparam logic [20:0] S_GRA     = 21'b1 << 7;
  localparam logic [20:0] S_GRB     = 21'b1 << 6;
  localparam logic [20:0] S_GRC     = 21'b1 << 5;
  localparam logic [20:0] S_ROUT    = 21'b1 << 4;
  localparam logic [20:0] S_BAOUT   = 21'b1 << 3;
  localparam logic [20:0] S_COUT    = 21'b1 << 2;
  localparam logic [20:0] S_READ    = 21'b1 << 1;
  localparam logic [20:0] S_WRITE   = 21'b1 << 0;
  localparam logic [20:0] S_NONE    = 21'b0;
  localparam logic [20:0] BUS_SRC   = S_PCOUT | S_ZLOW | S_MDROUT | S_ROUT |
                                      S_BAOUT | S_COUT | S_INPORT;

  typedef struct packed {
    logic [20:0] strobes;
    logic [4:0]  alu;
    logic        run;
    logic        mem;        // memory step: held while mem_rdy is low
    logic        fetch_end;  // last fetch step: IR is loaded after it
    logic        halt;       // HALT: repeats until clr
    logic        clr_here;   // directed clr right after this step
  } exp_t;

  exp_t q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic exp_t step(input logic [20:0] s, input logic [4:0] alu = 5'd0,
                                input logic mem = 1'b0);
    exp_t e;
    e = '0;
    e.strobes = s;
    e.alu     = alu;
    e.run     = 1'b1;
    e.mem     = mem;
    return e;
  endfunction

  task automatic push_fetch();
    exp_t e;
    q.push_back(step(S_PCOUT | S_MARIN | S_ZIN, 5'd12));
    q.push_back(step(S_ZLOW | S_PCIN | S_READ | S_MDRIN, 5'd0, 1'b1));
    e = step(S_MDROUT | S_IRIN);
    e.fetch_end = 1'b1;
    q.push_back(e);
  endtask

  task automatic push_reset();
    q.delete();
    q.push_back(step(S_NONE));
    push_fetch();
  endtask

  // Execute steps straight from the instruction definitions.
  task automatic push_exec(input logic [4:0] op, input logic con, input logic clr_t5);
    exp_t e;
    case (op)
      5'b00000, 5'b00001, 5'b00010: begin
        q.push_back(step(S_GRB | S_BAOUT | S_YIN));
        q.push_back(step(S_COUT | S_ZIN, 5'd2));
        if (op == 5'b00001) begin
          q.push_back(step(S_ZLOW | S_GRA | S_RIN));
        end else begin
          e = step(S_ZLOW | S_MARIN);
          e.clr_here = clr_t5;
          q.push_back(e);
          if (op == 5'b00000) begin
            q.push_back(step(S_READ | S_MDRIN, 5'd0, 1'b1));
            q.push_back(step(S_MDROUT | S_GRA | S_RIN));
          end else begin
            q.push_back(step(S_GRA | S_ROUT | S_MDRIN));
            q.push_back(step(S_WRITE, 5'd0, 1'b1));
          end
        end
      end
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        q.push_back(step(S_GRB | S_ROUT | S_YIN));
        q.push_back(step(S_GRC | S_ROUT | S_ZIN,
                         op == 5'b00011 ? 5'd2 : op == 5'b00100 ? 5'd3 :
                         op == 5'b00101 ? 5'd0 : 5'd1));
        q.push_back(step(S_ZLOW | S_GRA | S_RIN));
      end
      5'b01100, 5'b01101, 5'b01110: begin
        q.push_back(step(S_GRB | S_ROUT | S_YIN));
        q.push_back(step(S_COUT | S_ZIN,
                         op == 5'b01100 ? 5'd2 : op == 5'b01101 ? 5'd0 : 5'd1));
        q.push_back(step(S_ZLOW | S_GRA | S_RIN));
      end
      5'b10010: begin
        q.push_back(step(S_GRA | S_ROUT | S_CONIN));
        q.push_back(step(S_PCOUT | S_YIN));
        q.push_back(step(S_COUT | S_ZIN, 5'd2));
        q.push_back(step(con ? (S_ZLOW | S_PCIN) : S_NONE));
      end
      5'b10011: q.push_back(step(S_GRA | S_ROUT | S_PCIN));
      5'b10101: q.push_back(step(S_INPORT | S_GRA | S_RIN));
      5'b10110: q.push_back(step(S_GRA | S_ROUT | S_OUTPORT));
      5'b11011: begin
        q.push_back(step(S_NONE));
        e = '0;
        e.halt = 1'b1;
        q.push_back(e);
        return;
      end
      default: q.push_back(step(S_NONE));
    endcase
    push_fetch();
  endtask

  // Directed program first: ld, ldi, add, br not taken, br taken,
  // ld interrupted by clr in T5, halt. Then random instructions.
  logic [31:0] dir_ir  [7] = '{32'h00800075, 32'h08800005,
                               {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0},
                               {5'b10010, 4'd1, 4'd0, 19'd4},
                               {5'b10010, 4'd1, 4'd0, 19'd4},
                               32'h00800075, {5'b11011, 27'd0}};
  logic        dir_con [7] = '{0, 0, 0, 0, 1, 0, 0};
  logic        dir_clr [7] = '{0, 0, 0, 0, 0, 1, 0};

  logic [4:0] valid_ops [16] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011,
                                 5'b00100, 5'b00101, 5'b00110, 5'b01100,
                                 5'b01101, 5'b01110, 5'b10010, 5'b10011,
                                 5'b10101, 5'b10110, 5'b11010, 5'b11011};

  logic [26:0] obs;
  assign obs = {PCout, Zlowout, MDRout, InportOut, MARin, Zin, PCin, MDRin,
                IRin, Yin, Rin, CONin, OutportIn, Gra, Grb, Grc, Rout, BAout,
                Cout, Read, Write, ALU_Control, Run};

  initial begin
    exp_t        e;
    logic [26:0] want;
    logic [20:0] s_want;
    logic [4:0]  op;
    logic        con_pending;
    logic        advance;
    logic        do_clr;
    int          dir_idx  = 0;
    int          halt_cnt = 0;
    int          halt_len = 20;

    clr         = 1'b1;
    ir          = 32'h0;
    con_ff      = 1'b0;
    con_pending = 1'b0;
    mem_rdy     = 1'b1;
    push_reset();
    repeat (2) @(negedge clk);

    repeat (4000) begin
      clr = 1'b0;
      cyc++;
      e = q[0];
      s_want = e.strobes;
      if (e.mem && !mem_rdy) s_want = e.strobes & ~(S_ZLOW | S_PCIN | S_MDRIN);
      want = {s_want, e.alu, e.run};
      check($sformatf("strobes@%0d", cyc), {5'd0, obs}, {5'd0, want});
      check($sformatf("bus_one@%0d", cyc),
            {31'd0, $countones(obs[26:6] & BUS_SRC) <= 1}, 32'd1);
      check($sformatf("rd_wr@%0d", cyc), {31'd0, Read & Write}, 32'd0);

      advance = !e.halt && !(e.mem && !mem_rdy);
      if (advance) begin
        void'(q.pop_front());
        if ((e.strobes & S_CONIN) != 0) con_ff = con_pending;
        if (e.fetch_end) begin
          if (dir_idx < 7) begin
            ir          = dir_ir[dir_idx];
            con_pending = dir_con[dir_idx];
            push_exec(ir[31:27], con_pending, dir_clr[dir_idx]);
            dir_idx++;
          end else begin
            op = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31))
                                            : valid_ops[$urandom_range(0, 15)];
            ir          = {op, 27'($urandom)};
            con_pending = 1'($urandom_range(0, 1));
            push_exec(op, con_pending, 1'b0);
          end
        end
      end

      if (e.halt) halt_cnt++;
      do_clr = e.clr_here || (e.halt && halt_cnt >= halt_len) ||
               (dir_idx >= 7 && $urandom_range(0, 59) == 0);
      if (do_clr) begin
        clr      = 1'b1;
        halt_cnt = 0;
        halt_len = $urandom_range(1, 25);
        push_reset();
      end

`ifdef MEM_WAIT_EN
      if (dir_idx == 1 && cyc < 8) mem_rdy = (cyc >= 4);
      else                         mem_rdy = ($urandom_range(0, 2) != 0);
`else
      mem_rdy = 1'b1;
`endif
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
